// File: rtl/param_types.sv
// Shared linked-list request/response types and widths, plus the state encoding
// used by ll_req_arbiter.
package param_types;

  localparam int PTR_WD     = 4;
  localparam int WR_DATA_WD = 8;

  typedef enum logic [1:0] {
    REQ_READ   = 2'd0,
    REQ_INSERT = 2'd1,
    REQ_PUSH   = 2'd2,
    REQ_POP    = 2'd3
  } t_req_types;

  typedef enum logic [1:0] {
    RESP_OK    = 2'd0,
    RESP_DATA  = 2'd1,
    RESP_EMPTY = 2'd2,
    RESP_ERR   = 2'd3
  } t_resp_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    ERR_RESP  = 2'd3
  } t_ll_arb_state;

endpackage

// File: rtl/ll_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// scanning cyclically modulo N_CLI (works for non-power-of-2 client counts).
module ll_rr_pick #(
  parameter int N_CLI  = 4,
  parameter int IDX_WD = $clog2(N_CLI)
) (
  input  logic [N_CLI-1:0]  req,
  input  logic [IDX_WD-1:0] ptr,
  output logic [N_CLI-1:0]  gnt_onehot,
  output logic [IDX_WD-1:0] gnt_idx,
  output logic              any
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int i = 0; i < N_CLI; i++) begin
      idx = (int'(ptr) + i) % N_CLI;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IDX_WD'(idx);
      end
    end
  end

endmodule

// File: rtl/ll_req_arbiter.sv
// Round-robin arbiter sharing the single linked_list_top port among N_CLI clients.
// Define LL_ARB_TIMEOUT_EN to build the response watchdog and the ERR_RESP path.
module ll_req_arbiter
  import param_types::*;
#(
  parameter int N_CLI       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CLI-1:0]      cli_req_vld,
  input  t_req_types            cli_req_type [N_CLI],
  input  logic [PTR_WD-1:0]     cli_req_pos  [N_CLI],
  input  logic [WR_DATA_WD-1:0] cli_req_data [N_CLI],
  output logic [N_CLI-1:0]      cli_req_ack,
  output logic [N_CLI-1:0]      cli_resp_vld,
  output t_resp_types           cli_resp_type,
  output logic [WR_DATA_WD-1:0] cli_resp_data,
  output logic                  cli_resp_data_vld,
  output logic                  cli_resp_err,
  input  logic [N_CLI-1:0]      cli_resp_taken,
  output logic                  req_vld,
  output t_req_types            req_type,
  output logic [PTR_WD-1:0]     req_pos,
  output logic [WR_DATA_WD-1:0] req_data,
  input  logic                  intf_ready,
  input  logic                  resp_vld,
  input  t_resp_types           resp_type,
  input  logic [WR_DATA_WD-1:0] resp_data,
  input  logic                  resp_data_vld,
  output logic                  resp_taken
);

  localparam int IDX_WD = $clog2(N_CLI);

  t_ll_arb_state     state_q, state_d;
  logic [IDX_WD-1:0] rr_ptr_q, owner_q, gnt_idx, next_ptr;
  logic [N_CLI-1:0]  gnt_onehot;
  logic              gnt_any, capture, done;
  t_resp_types       last_type_q;

  ll_rr_pick #(.N_CLI(N_CLI), .IDX_WD(IDX_WD)) u_pick (
    .req        (cli_req_vld),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign next_ptr = (owner_q == IDX_WD'(N_CLI - 1)) ? '0 : owner_q + IDX_WD'(1);

`ifdef LL_ARB_TIMEOUT_EN
  localparam int WD_WD = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_WD-1:0] wdog_q;
  logic             wdog_hit;

  assign wdog_hit = (wdog_q == WD_WD'(TIMEOUT_CYC - 1));

  // Cleared while issuing so the count starts at 0 on the first WAIT_RESP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_q == ISSUE) begin
      wdog_q <= '0;
    end else if (state_q == WAIT_RESP && !wdog_hit) begin
      wdog_q <= wdog_q + WD_WD'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d           = state_q;
    cli_req_ack       = '0;
    cli_resp_vld      = '0;
    cli_resp_type     = last_type_q;
    cli_resp_data     = '0;
    cli_resp_data_vld = 1'b0;
    cli_resp_err      = 1'b0;
    resp_taken        = 1'b0;
    req_vld           = 1'b0;
    capture           = 1'b0;
    done              = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cli_req_ack = gnt_onehot;
          capture     = 1'b1;
          state_d     = ISSUE;
        end
`ifdef LL_ARB_TIMEOUT_EN
        resp_taken = resp_vld;
`endif
      end
      ISSUE: begin
        req_vld = 1'b1;
        if (intf_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        cli_resp_vld[owner_q] = resp_vld;
        cli_resp_type         = resp_type;
        cli_resp_data         = resp_data;
        cli_resp_data_vld     = resp_data_vld;
        resp_taken            = cli_resp_taken[owner_q];
        if (resp_vld && cli_resp_taken[owner_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
`ifdef LL_ARB_TIMEOUT_EN
        else if (!resp_vld && wdog_hit) begin
          state_d = ERR_RESP;
        end
`endif
      end
`ifdef LL_ARB_TIMEOUT_EN
      // A response arriving after the error is drained here as well as in IDLE.
      ERR_RESP: begin
        cli_resp_vld[owner_q] = 1'b1;
        cli_resp_err          = 1'b1;
        resp_taken            = resp_vld;
        if (cli_resp_taken[owner_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      req_type    <= REQ_READ;
      req_pos     <= '0;
      req_data    <= '0;
      last_type_q <= RESP_OK;
    end else begin
      state_q <= state_d;
      if (capture) begin
        owner_q  <= gnt_idx;
        req_type <= cli_req_type[gnt_idx];
        req_pos  <= cli_req_pos[gnt_idx];
        req_data <= cli_req_data[gnt_idx];
      end
      if (done) rr_ptr_q <= next_ptr;
      if (done && state_q == WAIT_RESP) last_type_q <= resp_type;
    end
  end

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Bench for ll_req_arbiter: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model (free / issuing / outstanding, rr pointer).
`timescale 1ns/1ps
module tb_ll_req_arbiter;
  import param_types::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [N-1:0]          cli_req_vld;
  t_req_types            cli_req_type [N];
  logic [PTR_WD-1:0]     cli_req_pos  [N];
  logic [WR_DATA_WD-1:0] cli_req_data [N];
  logic [N-1:0]          cli_req_ack, cli_resp_vld, cli_resp_taken;
  t_resp_types           cli_resp_type, resp_type;
  logic [WR_DATA_WD-1:0] cli_resp_data, resp_data, req_data;
  logic                  cli_resp_data_vld, cli_resp_err, req_vld, intf_ready;
  logic                  resp_vld, resp_data_vld, resp_taken;
  t_req_types            req_type;
  logic [PTR_WD-1:0]     req_pos;

  ll_req_arbiter #(.N_CLI(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cli_req_vld(cli_req_vld), .cli_req_type(cli_req_type), .cli_req_pos(cli_req_pos),
    .cli_req_data(cli_req_data), .cli_req_ack(cli_req_ack), .cli_resp_vld(cli_resp_vld),
    .cli_resp_type(cli_resp_type), .cli_resp_data(cli_resp_data),
    .cli_resp_data_vld(cli_resp_data_vld), .cli_resp_err(cli_resp_err),
    .cli_resp_taken(cli_resp_taken), .req_vld(req_vld), .req_type(req_type),
    .req_pos(req_pos), .req_data(req_data), .intf_ready(intf_ready),
    .resp_vld(resp_vld), .resp_type(resp_type), .resp_data(resp_data),
    .resp_data_vld(resp_data_vld), .resp_taken(resp_taken)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: m_owner < 0 means no transaction; m_sent means accepted downstream.
  int                    m_ptr, m_owner, ds_delay, done_cnt;
  bit                    m_sent;
  t_req_types            m_type;
  logic [PTR_WD-1:0]     m_pos;
  logic [WR_DATA_WD-1:0] m_data;
  t_resp_types           rs_type;
  logic [WR_DATA_WD-1:0] rs_data;
  logic                  rs_dvld;
  bit                    cl_want [N];
  bit                    cl_hold [N];
  t_req_types            cl_type [N];
  logic [PTR_WD-1:0]     cl_pos  [N];
  logic [WR_DATA_WD-1:0] cl_data [N];
  int                    p_req, p_ready, p_taken, p_spur, ds_max, hold_taken;
  bit                    force_ready_low, ds_never, chk_en;
  int                    grant_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      if (!cl_want[i] && !cl_hold[i] && $urandom_range(0, 99) < p_req) begin
        cl_want[i] = 1'b1;
        cl_type[i] = t_req_types'($urandom_range(0, 3));
        cl_pos[i]  = PTR_WD'($urandom);
        cl_data[i] = WR_DATA_WD'($urandom);
      end
      cl_hold[i]        = 1'b0;
      cli_req_vld[i]    = cl_want[i];
      cli_req_type[i]   = cl_type[i];
      cli_req_pos[i]    = cl_pos[i];
      cli_req_data[i]   = cl_data[i];
      cli_resp_taken[i] = (hold_taken == 0) && ($urandom_range(0, 99) < p_taken);
    end
    intf_ready = !force_ready_low && ($urandom_range(0, 99) < p_ready);
    if (m_owner >= 0 && m_sent) begin
      resp_vld      = !ds_never && ds_delay == 0;
      resp_type     = rs_type;
      resp_data     = rs_data;
      resp_data_vld = rs_dvld;
    end else begin
      resp_vld      = $urandom_range(0, 99) < p_spur;
      resp_type     = t_resp_types'($urandom_range(0, 3));
      resp_data     = WR_DATA_WD'($urandom);
      resp_data_vld = 1'($urandom);
    end
  endtask

  task automatic check_output();
    logic [N-1:0] e_ack, e_rvld;
    logic         e_req_vld, e_taken;
    int           w;
    e_ack = '0; e_rvld = '0; e_req_vld = 1'b0; e_taken = 1'b0; w = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && cli_req_vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) e_ack[w] = 1'b1;
`ifdef LL_ARB_TIMEOUT_EN
      e_taken = resp_vld;
`endif
    end else if (!m_sent) begin
      e_req_vld = 1'b1;
    end else begin
      if (resp_vld) e_rvld[m_owner] = 1'b1;
      e_taken = cli_resp_taken[m_owner];
    end
    if (chk_en) begin
      check("cli_req_ack", 32'(cli_req_ack), 32'(e_ack));
      check("req_vld", 32'(req_vld), 32'(e_req_vld));
      check("cli_resp_vld", 32'(cli_resp_vld), 32'(e_rvld));
      check("resp_taken", 32'(resp_taken), 32'(e_taken));
      check("cli_resp_err", 32'(cli_resp_err), 32'd0);
      if (e_req_vld) begin
        check("req_type", 32'(req_type), 32'(m_type));
        check("req_pos", 32'(req_pos), 32'(m_pos));
        check("req_data", 32'(req_data), 32'(m_data));
      end
      if (e_rvld != '0) begin
        check("cli_resp_type", 32'(cli_resp_type), 32'(rs_type));
        check("cli_resp_data", 32'(cli_resp_data), 32'(rs_data));
        check("cli_resp_data_vld", 32'(cli_resp_data_vld), 32'(rs_dvld));
      end
    end
    if (w >= 0) begin
      m_owner = w; m_sent = 1'b0;
      m_type = cli_req_type[w]; m_pos = cli_req_pos[w]; m_data = cli_req_data[w];
      cl_want[w] = 1'b0; cl_hold[w] = 1'b1;
      grant_log.push_back(w);
    end else if (m_owner >= 0 && !m_sent) begin
      if (intf_ready) begin
        m_sent   = 1'b1;
        ds_delay = $urandom_range(0, ds_max);
        rs_type  = t_resp_types'($urandom_range(0, 3));
        rs_data  = WR_DATA_WD'($urandom);
        rs_dvld  = 1'($urandom);
      end
    end else if (m_owner >= 0) begin
      if (resp_vld && cli_resp_taken[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_sent = 1'b0; done_cnt++;
      end else if (ds_delay > 0) begin
        ds_delay--;
      end
    end
    if (hold_taken > 0) hold_taken--;
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1 apply_stimulus();
    #3 check_output();
  endtask

  task automatic run_until_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin step(); n++; end
    check("done_in_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic run_until_accept(input int limit);
    int n = 0;
    while (!(m_owner >= 0 && m_sent) && n < limit) begin step(); n++; end
    check("accept_in_budget", 32'(m_owner >= 0 && m_sent), 32'd1);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    p_req = 0; p_spur = 0; p_ready = 100; p_taken = 100;
    while ((m_owner >= 0 || cl_want[0] || cl_want[1] || cl_want[2] || cl_want[3]) && n < limit) begin
      step(); n++;
    end
    check("drain_in_budget", 32'(m_owner < 0), 32'd1);
  endtask

  task automatic clear_inputs();
    cli_req_vld = '0; cli_resp_taken = '0; intf_ready = 1'b0; resp_vld = 1'b0;
    resp_type = RESP_OK; resp_data = '0; resp_data_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      cli_req_type[i] = REQ_READ; cli_req_pos[i] = '0; cli_req_data[i] = '0;
      cl_want[i] = 1'b0; cl_hold[i] = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 32'({cli_req_ack, cli_resp_vld, req_vld, resp_taken,
                                cli_resp_err, cli_resp_data_vld}), 32'd0);
    check({name, "_fields"}, 32'({req_type, req_pos, req_data, cli_resp_type, cli_resp_data}), 32'd0);
  endtask

  initial begin
    int obs_ack, obs_req, req_hi, hold_ok, err_n;
    logic [N-1:0]          ack_seen, resp_seen;
    logic [PTR_WD-1:0]     pos_seen;
    logic [WR_DATA_WD-1:0] data_seen;

    m_ptr = 0; m_owner = -1; m_sent = 1'b0; ds_delay = 0; done_cnt = 0;
    p_req = 0; p_ready = 100; p_taken = 100; p_spur = 0; ds_max = 2; hold_taken = 0;
    force_ready_low = 1'b0; ds_never = 1'b0; chk_en = 1'b1;
    reset_n = 1'b0;
    clear_inputs();
    #12;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // Single client 2 push, pos 3, data 0xA5.
    cl_want[2] = 1'b1; cl_type[2] = REQ_PUSH; cl_pos[2] = 4'd3; cl_data[2] = 8'hA5;
    obs_ack = -1; obs_req = -1; ack_seen = '0; resp_seen = '0; pos_seen = '0; data_seen = '0;
    for (int n = 0; n < 30 && done_cnt < 1; n++) begin
      step();
      if (cli_req_ack != '0 && obs_ack < 0) begin obs_ack = cyc; ack_seen = cli_req_ack; end
      if (req_vld && obs_req < 0) begin obs_req = cyc; pos_seen = req_pos; data_seen = req_data; end
      if (cli_resp_vld != '0) resp_seen = cli_resp_vld;
    end
    check("t1_ack_onehot", 32'(ack_seen), 32'h4);
    check("t1_req_latency", obs_req - obs_ack, 1);
    check("t1_req_pos", 32'(pos_seen), 32'd3);
    check("t1_req_data", 32'(data_seen), 32'hA5);
    check("t1_resp_route", 32'(resp_seen), 32'h4);
    check("t1_model_ptr", m_ptr, 3);
    check("t1_model_grant", grant_log[0], 2);

    // Reset while client 1's transaction waits for its response.
    cl_want[1] = 1'b1; cl_type[1] = REQ_POP; cl_pos[1] = 4'd5; cl_data[1] = 8'h3C;
    ds_never = 1'b1;
    run_until_accept(20);
    for (int n = 0; n < 3; n++) step();
    @(posedge clk);
    #1 reset_n = 1'b0;
    clear_inputs();
    #1 check_all_zero("midreset");
    m_ptr = 0; m_owner = -1; m_sent = 1'b0; ds_never = 1'b0;
    #10;
    @(negedge clk) reset_n = 1'b1;

    // All four clients request continuously.
    grant_log.delete();
    p_req = 100; ds_max = 2;
    run_until_done(done_cnt + 5, 200);
    check("rr_g0", grant_log[0], 0);
    check("rr_g1", grant_log[1], 1);
    check("rr_g2", grant_log[2], 2);
    check("rr_g3", grant_log[3], 3);
    check("rr_g4", grant_log[4], 0);
    drain(100);

    // intf_ready held low for 10 cycles in ISSUE.
    cl_want[0] = 1'b1; cl_type[0] = REQ_INSERT; cl_pos[0] = 4'd7; cl_data[0] = 8'h5A;
    for (int n = 0; n < 10 && m_owner < 0; n++) step();
    force_ready_low = 1'b1; req_hi = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (req_vld && req_pos == 4'd7 && req_data == 8'h5A && req_type == REQ_INSERT) req_hi++;
    end
    check("stall_req_held", req_hi, 10);
    force_ready_low = 1'b0;
    step();
    check("stall_xfer_cycle", 32'(req_vld), 32'd1);
    step();
    check("stall_after_xfer", 32'(req_vld), 32'd0);
    run_until_done(done_cnt + 1, 50);

    // Owner 3 withholds cli_resp_taken for 5 cycles while client 0 waits.
    ds_max = 0;
    cl_want[3] = 1'b1; cl_type[3] = REQ_READ; cl_pos[3] = 4'd9; cl_data[3] = 8'h11;
    run_until_accept(20);
    hold_taken = 5;
    cl_want[0] = 1'b1; cl_type[0] = REQ_PUSH; cl_pos[0] = 4'd1; cl_data[0] = 8'h22;
    hold_ok = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (cli_resp_vld == 4'b1000 && !resp_taken && cli_req_ack == '0) hold_ok++;
    end
    check("hold_resp_pending", hold_ok, 5);
    step();
    check("hold_taken_release", 32'(resp_taken), 32'd1);
    step();
    check("hold_next_grant", 32'(cli_req_ack), 32'h1);
    run_until_done(done_cnt + 1, 50);

    // Randomized traffic with stalls, slow responses and stray downstream responses.
    p_req = 30; p_ready = 60; p_taken = 60; p_spur = 20; ds_max = 4;
    for (int n = 0; n < 2000; n++) step();
    drain(300);

`ifdef LL_ARB_TIMEOUT_EN
    // Watchdog: no downstream response for client 1.
    cl_want[1] = 1'b1; cl_type[1] = REQ_READ; cl_pos[1] = 4'd2; cl_data[1] = 8'h77;
    ds_never = 1'b1;
    run_until_accept(20);
    chk_en = 1'b0; p_taken = 0; err_n = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (cli_resp_err && err_n < 0) begin
        err_n = n;
        check("tmo_resp_vld", 32'(cli_resp_vld), 32'h2);
        check("tmo_resp_data", 32'({cli_resp_data, cli_resp_data_vld}), 32'd0);
      end
    end
    check("tmo_cycle", err_n, TMO + 1);
    p_taken = 100;
    step();
    m_ptr = 2; m_owner = -1; m_sent = 1'b0; ds_never = 1'b0; chk_en = 1'b1;
    p_spur = 100;
    step();
    check("tmo_drain_taken", 32'(resp_taken), 32'd1);
    drain(50);
`else
    err_n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
